// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the per-pad GPIO configuration register:
// field bit positions, word width, state encoding and decoded pad-control bundle.
package gpio_cfg_pkg;

    localparam int GPIO_CFG_W   = 10;

    localparam int CFG_MGMT_ENA = 0;
    localparam int CFG_OUT_DIS  = 1;
    localparam int CFG_HOLD_OVR = 2;
    localparam int CFG_INP_DIS  = 3;
    localparam int CFG_PU       = 4;
    localparam int CFG_PD       = 5;
    localparam int CFG_SLEW     = 6;
    localparam int CFG_SCHMITT  = 7;
    localparam int CFG_DRV_LO   = 8;
    localparam int CFG_DRV_HI   = 9;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        IDLE = 1'b1
    } cfg_state_e;

    typedef struct packed {
        logic       mgmt_ena;
        logic       out_dis;
        logic       hold_ovr;
        logic       inp_dis;
        logic       pu_ena;
        logic       pd_ena;
        logic       slew_fast;
        logic       schmitt_ena;
        logic [1:0] drive_sel;
    } pad_ctrl_t;

    // Pull-up and pull-down fighting would short the pad; pull-up wins.
    function automatic logic pd_effective(input logic pu, input logic pd);
        return pd & ~pu;
    endfunction

endpackage

// File: rtl/gpio_config_shifter_if.sv
// Housekeeping serial daisy-chain link: strobes and data toward a pad register,
// chained data back out toward the next pad.
interface gpio_config_shifter_if;

    logic serial_shift;
    logic serial_data_in;
    logic serial_load;
    logic serial_capture;
    logic serial_data_out;

    modport master (
        output serial_shift,
        output serial_data_in,
        output serial_load,
        output serial_capture,
        input  serial_data_out
    );

    modport slave (
        input  serial_shift,
        input  serial_data_in,
        input  serial_load,
        input  serial_capture,
        output serial_data_out
    );

endinterface

// File: rtl/gpio_cfg_decode.sv
// Combinational decode of a configuration word into pad-cell control fields.
// Also used by the housekeeping readback mirror, so it holds no state.
module gpio_cfg_decode
    import gpio_cfg_pkg::*;
(
    input  logic [GPIO_CFG_W-1:0] cfg_i,
    output pad_ctrl_t             pad_o
);

    assign pad_o.mgmt_ena    = cfg_i[CFG_MGMT_ENA];
    assign pad_o.out_dis     = cfg_i[CFG_OUT_DIS];
    assign pad_o.hold_ovr    = cfg_i[CFG_HOLD_OVR];
    assign pad_o.inp_dis     = cfg_i[CFG_INP_DIS];
    assign pad_o.pu_ena      = cfg_i[CFG_PU];
    assign pad_o.pd_ena      = pd_effective(cfg_i[CFG_PU], cfg_i[CFG_PD]);
    assign pad_o.slew_fast   = cfg_i[CFG_SLEW];
    assign pad_o.schmitt_ena = cfg_i[CFG_SCHMITT];
    assign pad_o.drive_sel   = cfg_i[CFG_DRV_HI:CFG_DRV_LO];

endmodule

// File: rtl/gpio_config_shifter.sv
// Per-pad GPIO configuration register: loads tie-cell defaults after reset,
// then takes serial reconfiguration/readback over the housekeeping daisy chain.
module gpio_config_shifter
    import gpio_cfg_pkg::*;
#(
    parameter int WIDTH = GPIO_CFG_W,
    parameter int CNT_W = 4
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [WIDTH-1:0]   gpio_defaults,
    gpio_config_shifter_if.slave ser,
    output logic [WIDTH-1:0]   config_q,
    output logic               config_valid,
    output logic               load_err,
    output logic [CNT_W-1:0]   shift_count,
    output logic               mgmt_ena,
    output logic               out_dis,
    output logic               hold_ovr,
    output logic               inp_dis,
    output logic               pu_ena,
    output logic               pd_ena,
    output logic               slew_fast,
    output logic               schmitt_ena,
    output logic [1:0]         drive_sel
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    cfg_state_e       state_q,     state_d;
    logic [WIDTH-1:0] cfg_q,       cfg_d;
    logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic             valid_q,     valid_d;
    logic             err_q,       err_d;
    pad_ctrl_t        pad_s;

    // State and datapath registers; defaults are deliberately not reset values.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= INIT;
            cfg_q       <= '0;
            shift_reg_q <= '0;
            count_q     <= CNT_ZERO;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            shift_reg_q <= shift_reg_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic: one action per cycle, load > capture > shift.
    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        shift_reg_d = shift_reg_q;
        count_d     = count_q;
        valid_d     = valid_q;
        err_d       = err_q;
        case (state_q)
            INIT: begin
                cfg_d       = gpio_defaults;
                shift_reg_d = gpio_defaults;
                valid_d     = 1'b1;
                state_d     = IDLE;
            end
            IDLE: begin
                if (ser.serial_load) begin
                    cfg_d   = shift_reg_q;
                    err_d   = (count_q < CNT_FULL);
                    count_d = CNT_ZERO;
                end else if (ser.serial_capture) begin
                    shift_reg_d = cfg_q;
                    count_d     = CNT_ZERO;
                end else if (ser.serial_shift) begin
                    shift_reg_d = {shift_reg_q[WIDTH-2:0], ser.serial_data_in};
                    // Saturate so long pass-through shifting never wraps.
                    if (count_q == CNT_FULL) begin
                        count_d = count_q;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    gpio_cfg_decode u_decode (
        .cfg_i (cfg_q[GPIO_CFG_W-1:0]),
        .pad_o (pad_s)
    );

    assign config_q            = cfg_q;
    assign config_valid        = valid_q;
    assign load_err            = err_q;
    assign shift_count         = count_q;
    assign ser.serial_data_out = shift_reg_q[WIDTH-1];

    assign mgmt_ena    = pad_s.mgmt_ena;
    assign out_dis     = pad_s.out_dis;
    assign hold_ovr    = pad_s.hold_ovr;
    assign inp_dis     = pad_s.inp_dis;
    assign pu_ena      = pad_s.pu_ena;
    assign pd_ena      = pad_s.pd_ena;
    assign slew_fast   = pad_s.slew_fast;
    assign schmitt_ena = pad_s.schmitt_ena;
    assign drive_sel   = pad_s.drive_sel;

endmodule

// File: tb/tb_gpio_config_shifter.sv
// Randomized self-checking bench for gpio_config_shifter against an
// integer-arithmetic reference model of the configuration register.
module tb_gpio_config_shifter;

    logic       clk;
    logic       rst;
    logic [9:0] defaults;
    logic [9:0] config_q;
    logic       config_valid, load_err;
    logic [3:0] shift_count;
    logic       mgmt_ena, out_dis, hold_ovr, inp_dis, pu_ena, pd_ena, slew_fast, schmitt_ena;
    logic [1:0] drive_sel;

    gpio_config_shifter_if ser_if ();

    gpio_config_shifter #(.WIDTH(10), .CNT_W(4)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .gpio_defaults (defaults),
        .ser           (ser_if),
        .config_q      (config_q),
        .config_valid  (config_valid),
        .load_err      (load_err),
        .shift_count   (shift_count),
        .mgmt_ena      (mgmt_ena),
        .out_dis       (out_dis),
        .hold_ovr      (hold_ovr),
        .inp_dis       (inp_dis),
        .pu_ena        (pu_ena),
        .pd_ena        (pd_ena),
        .slew_fast     (slew_fast),
        .schmitt_ena   (schmitt_ena),
        .drive_sel     (drive_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state as plain integers.
    int m_cfg, m_sreg, m_cnt, m_err, m_valid;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cfg = 0; m_sreg = 0; m_cnt = 0; m_err = 0; m_valid = 0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (m_valid == 0) begin
            m_cfg = int'(defaults); m_sreg = int'(defaults); m_valid = 1;
        end else if (ser_if.serial_load) begin
            m_err = (m_cnt < 10) ? 1 : 0;
            m_cfg = m_sreg;
            m_cnt = 0;
        end else if (ser_if.serial_capture) begin
            m_sreg = m_cfg;
            m_cnt = 0;
        end else if (ser_if.serial_shift) begin
            m_sreg = ((m_sreg * 2) + int'(ser_if.serial_data_in)) % 1024;
            m_cnt = (m_cnt < 10) ? m_cnt + 1 : 10;
        end
    endtask

    function automatic int fbit(input int w, input int b);
        return (w >> b) & 1;
    endfunction

    task automatic check_all(input string tag);
        check_eq({tag, ".cfg"},   32'(config_q),     32'(m_cfg));
        check_eq({tag, ".valid"}, 32'(config_valid), 32'(m_valid));
        check_eq({tag, ".err"},   32'(load_err),     32'(m_err));
        check_eq({tag, ".cnt"},   32'(shift_count),  32'(m_cnt));
        check_eq({tag, ".sdo"},   32'(ser_if.serial_data_out), 32'(fbit(m_sreg, 9)));
        check_eq({tag, ".fields"},
                 {22'd0, mgmt_ena, out_dis, hold_ovr, inp_dis, pu_ena, pd_ena,
                  slew_fast, schmitt_ena, drive_sel},
                 32'({fbit(m_cfg,0) != 0, fbit(m_cfg,1) != 0, fbit(m_cfg,2) != 0,
                      fbit(m_cfg,3) != 0, fbit(m_cfg,4) != 0,
                      (fbit(m_cfg,5) == 1 && fbit(m_cfg,4) == 0),
                      fbit(m_cfg,6) != 0, fbit(m_cfg,7) != 0,
                      2'((m_cfg >> 8) & 3)}));
    endtask

    task automatic drive(input logic ld, input logic cap, input logic sh, input logic din);
        ser_if.serial_load    = ld;
        ser_if.serial_capture = cap;
        ser_if.serial_shift   = sh;
        ser_if.serial_data_in = din;
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic shift_word(input logic [9:0] w, input string tag);
        for (int i = 9; i >= 0; i--) begin
            drive(1'b0, 1'b0, 1'b1, w[i]);
            tick(tag);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [9:0] w;
        logic [9:0] saved;
        rst = 1'b1;
        defaults = 10'h087;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_all("reset");

        // Release: defaults appear one edge later.
        rst = 1'b0;
        tick("init");
        check_eq("init.cfg087", 32'(config_q), 32'h087);
        check_eq("init.pads", {23'd0, mgmt_ena, out_dis, hold_ovr, schmitt_ena, pu_ena, pd_ena, inp_dis,
                 slew_fast, drive_sel}, 32'b1111_0000_00);

        shift_word(10'h235, "sh235");
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick("ld235");
        check_eq("ld235.cfg", 32'(config_q), 32'h235);
        check_eq("ld235.drv", 32'(drive_sel), 32'd2);
        check_eq("ld235.pupd", {30'd0, pu_ena, pd_ena}, 32'b10);
        check_eq("ld235.err", 32'(load_err), 32'd0);
        check_eq("ld235.cnt", 32'(shift_count), 32'd0);

        // Short load: 4 bits 1,0,1,0 on top of the 0x235 left in the shift register.
        w = 10'b1010;
        for (int i = 3; i >= 0; i--) begin
            drive(1'b0, 1'b0, 1'b1, w[i]);
            tick("sh4");
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick("ld4");
        check_eq("ld4.err", 32'(load_err), 32'd1);
        check_eq("ld4.cfg", 32'(config_q), 32'h35A);
        shift_word(10'h3C1, "sh10");
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick("ld10");
        check_eq("ld10.errclr", 32'(load_err), 32'd0);

        // Capture readback of 0x087, then pass-through beyond WIDTH.
        shift_word(10'h087, "sh087");
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick("ld087");
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        tick("cap");
        w = 10'h087;
        check_eq("cap.sdo", 32'(ser_if.serial_data_out), 32'(w[9]));
        for (int k = 1; k <= 13; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            tick("rdback");
            check_eq("rdback.sdo", 32'(ser_if.serial_data_out), (k <= 9) ? 32'(w[9-k]) : 32'd0);
            check_eq("rdback.cnt", 32'(shift_count), (k < 10) ? 32'(k) : 32'd10);
        end
        check_eq("rdback.noerr", 32'(load_err), 32'd0);

        // Load+shift: load takes pre-cycle shift register, shift dropped.
        shift_word(10'h2D3, "shpre");
        saved = 10'h2D3;
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        tick("ldsh");
        check_eq("ldsh.cfg", 32'(config_q), 32'(saved));
        check_eq("ldsh.sdo", 32'(ser_if.serial_data_out), 32'(saved[9]));
        // Capture+shift: capture wins.
        shift_word(10'h000, "shz");
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        tick("capsh");
        check_eq("capsh.cnt", 32'(shift_count), 32'd0);
        check_eq("capsh.sdo", 32'(ser_if.serial_data_out), 32'(saved[9]));

        // Async reset after 5 shifts clears everything without a clock edge.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
            tick("sh5");
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        defaults = 10'h1B4;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("arst");
        check_eq("arst.cfg0", 32'(config_q), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick("rerel");
        check_eq("rerel.cfg", 32'(config_q), 32'h1B4);
        check_eq("rerel.cnt", 32'(shift_count), 32'd0);

        // Randomized traffic, including occasional resets and default changes.
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) defaults = 10'($urandom);
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1) == 1, 1'($urandom_range(0, 1)));
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
